// File: rtl/fetch_queue_if.sv
// Fetch-queue bundle: instruction memory port, redirect/stall control and decode-side output.
// master = surrounding pipeline/memory, slave = fetch_queue.
interface fetch_queue_if #(
  parameter int CNT_W = 3
);
  logic              imem_rd;
  logic [15:0]       imem_addr;
  logic [15:0]       imem_data;
  logic              redirect;
  logic [15:0]       redirect_pc;
  logic              stall;
  logic              out_valid;
  logic [15:0]       out_instr;
  logic [15:0]       out_pc_plus_two;
  logic [CNT_W-1:0]  count;

  modport master (
    output imem_data, redirect, redirect_pc, stall,
    input  imem_rd, imem_addr, out_valid, out_instr, out_pc_plus_two, count
  );

  modport slave (
    input  imem_data, redirect, redirect_pc, stall,
    output imem_rd, imem_addr, out_valid, out_instr, out_pc_plus_two, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues 1-cycle-latency imem reads and buffers {instr, pc+2}.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the queue is empty.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic         clk,
  input  logic         rst,
  fetch_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [15:0]      r_fetch_pc;
  logic [15:0]      r_inflight_pc;
  logic             r_inflight;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_occ;
  logic [15:0]      r_q_instr [DEPTH];
  logic [15:0]      r_q_pc2   [DEPTH];

  logic        w_issue;
  logic        w_resp;
  logic        w_bypass;
  logic        w_empty;
  logic        w_out_valid;
  logic        w_pop;
  logic        w_wr;
  logic        w_rd;
  logic [15:0] w_resp_pc2;

  // The in-flight slot counts against capacity so a response can never land on a full queue.
  assign w_issue    = !rst && !bus.redirect &&
                      ((r_occ + CNT_W'(r_inflight)) < CNT_W'(DEPTH));
  // A response landing in a redirect cycle belongs to the old stream and is dropped.
  assign w_resp     = !rst && r_inflight && !bus.redirect;
  assign w_resp_pc2 = r_inflight_pc + 16'd2;
  assign w_empty    = (r_occ == '0);

`ifdef FETCH_BYPASS_EN
  assign w_bypass = w_empty && w_resp;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_out_valid = !rst && (!w_empty || w_bypass);
  assign w_pop       = w_out_valid && !bus.stall && !bus.redirect;
  assign w_wr        = w_resp && !(w_bypass && w_pop);
  assign w_rd        = w_pop && !w_bypass;

  assign bus.imem_rd   = w_issue;
  assign bus.imem_addr = rst ? 16'h0000 : r_fetch_pc;
  assign bus.out_valid = w_out_valid;
  assign bus.count     = r_occ;

  always_comb begin
    bus.out_instr       = 16'h0000;
    bus.out_pc_plus_two = 16'h0000;
    if (w_bypass) begin
      bus.out_instr       = bus.imem_data;
      bus.out_pc_plus_two = w_resp_pc2;
    end else if (w_out_valid) begin
      bus.out_instr       = r_q_instr[r_head];
      bus.out_pc_plus_two = r_q_pc2[r_head];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= 16'h0000;
      r_inflight_pc <= 16'h0000;
      r_inflight    <= 1'b0;
      r_head        <= '0;
      r_tail        <= '0;
      r_occ         <= '0;
    end else if (bus.redirect) begin
      r_fetch_pc <= {bus.redirect_pc[15:1], 1'b0};
      r_inflight <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
      r_occ      <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_fetch_pc    <= r_fetch_pc + 16'd2;
        r_inflight_pc <= r_fetch_pc;
      end
      if (w_wr) r_tail <= r_tail + 1'b1;
      if (w_rd) r_head <= r_head + 1'b1;
      r_occ <= r_occ + CNT_W'(w_wr) - CNT_W'(w_rd);
    end
  end

  // Storage needs no reset: entries are only observed while counted in r_occ.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_q_instr[r_tail] <= bus.imem_data;
      r_q_pc2[r_tail]   <= w_resp_pc2;
    end
  end
endmodule
